// File: rtl/iccm_loader_pkg.sv
// Shared constants and state encoding for the ICCM byte-stream loader.
// Imported by the loader top and its word assembler.
package iccm_loader_pkg;

  localparam int LOADER_AW = 11;
  localparam int LOADER_DW = 32;

  localparam logic [7:0] OP_WRITE  = 8'hA5;
  localparam logic [7:0] OP_BURST  = 8'hB4;
  localparam logic [7:0] OP_FINISH = 8'h5A;

  typedef logic [3:0] loader_state_e;

  localparam loader_state_e ST_IDLE  = 4'd0;
  localparam loader_state_e ST_ADDR0 = 4'd1;
  localparam loader_state_e ST_ADDR1 = 4'd2;
  localparam loader_state_e ST_CNT0  = 4'd3;
  localparam loader_state_e ST_CNT1  = 4'd4;
  localparam loader_state_e ST_DATA  = 4'd5;
  localparam loader_state_e ST_CSUM  = 4'd6;
  localparam loader_state_e ST_WRITE = 4'd7;
  localparam loader_state_e ST_DONE  = 4'd8;

endpackage

// File: rtl/iccm_loader_word_asm.sv
// Little-endian 4-byte word assembler with running XOR checksum.
// last_o flags that the next accepted byte completes the word.
module iccm_loader_word_asm
  import iccm_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        last_o
);

  logic [1:0] idx;

  assign last_o = (idx == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_o <= '0;
      csum_o <= '0;
      idx    <= '0;
    end else if (clr_i) begin
      csum_o <= '0;
      idx    <= '0;
    end else if (en_i) begin
      word_o[8*idx +: 8] <= byte_i;
      csum_o <= csum_o ^ byte_i;
      idx    <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/iccm_loader.sv
// Framed byte-stream loader driving the ICCM boot write port.
// Parses WRITE/BURST/FINISH frames and issues one strobe per good word.
module iccm_loader
  import iccm_loader_pkg::*;
#(
  parameter int AW = LOADER_AW,
  parameter int DW = LOADER_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_valid_i,
  input  logic [7:0]    rx_data_i,
  output logic          rx_ready_o,
  output logic          iccm_we_o,
  output logic [DW-1:0] iccm_wdata_o,
  output logic [DW-1:0] iccm_wmask_o,
  output logic [AW-1:0] iccm_waddr_o,
  output logic          finish_o,
  output logic          err_o,
  output logic          busy_o
);

  loader_state_e state;
  logic [AW-1:0] addr;
  logic [7:0]    addr_lo;
  logic [15:0]   remaining;
  logic          burst;
  logic          acc;
  logic          asm_clr;
  logic          asm_en;
  logic [31:0]   word;
  logic [7:0]    csum;
  logic          last;

  assign rx_ready_o = !rst_i && (state != ST_WRITE);
  assign acc = rx_valid_i && rx_ready_o;
  assign busy_o = (state != ST_IDLE) && (state != ST_DONE);
  assign asm_en = acc && (state == ST_DATA);
  assign asm_clr = (state == ST_IDLE) ||
                   (acc && (state == ST_CSUM));

  iccm_loader_word_asm u_asm (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (asm_clr),
    .en_i   (asm_en),
    .byte_i (rx_data_i),
    .word_o (word),
    .csum_o (csum),
    .last_o (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      addr         <= '0;
      addr_lo      <= '0;
      remaining    <= '0;
      burst        <= 1'b0;
      iccm_we_o    <= 1'b0;
      iccm_wdata_o <= '0;
      iccm_wmask_o <= '0;
      iccm_waddr_o <= '0;
      finish_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      iccm_we_o <= 1'b0;
      unique case (state)
        ST_IDLE: if (acc) begin
          case (rx_data_i)
            OP_WRITE: begin
              remaining <= 16'd1;
              burst     <= 1'b0;
              state     <= ST_ADDR0;
            end
            OP_BURST: begin
              burst <= 1'b1;
              state <= ST_ADDR0;
            end
            OP_FINISH: begin
              finish_o <= 1'b1;
              state    <= ST_DONE;
            end
            default: err_o <= 1'b1;
          endcase
        end
        ST_ADDR0: if (acc) begin
          addr_lo <= rx_data_i;
          state   <= ST_ADDR1;
        end
        ST_ADDR1: if (acc) begin
          addr  <= AW'({rx_data_i[2:0], addr_lo});
          state <= burst ? ST_CNT0 : ST_DATA;
        end
        ST_CNT0: if (acc) begin
          remaining[7:0] <= rx_data_i;
          state <= ST_CNT1;
        end
        ST_CNT1: if (acc) begin
          remaining[15:8] <= rx_data_i;
          if ({rx_data_i, remaining[7:0]} == 16'd0)
            state <= ST_IDLE;
          else
            state <= ST_DATA;
        end
        ST_DATA: if (acc && last) begin
          state <= ST_CSUM;
        end
        ST_CSUM: if (acc) begin
          if (rx_data_i == csum) begin
            iccm_we_o    <= 1'b1;
            iccm_wdata_o <= DW'(word);
            iccm_wmask_o <= '1;
            iccm_waddr_o <= addr;
            state        <= ST_WRITE;
          end else begin
            // Bad word is dropped but still consumes its slot in the burst.
            err_o     <= 1'b1;
            addr      <= addr + AW'(1);
            remaining <= remaining - 16'd1;
            state <= (remaining > 16'd1) ? ST_DATA : ST_IDLE;
          end
        end
        ST_WRITE: begin
          addr      <= addr + AW'(1);
          remaining <= remaining - 16'd1;
          state <= (remaining != 16'd1) ? ST_DATA : ST_IDLE;
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iccm_loader.sv
// Directed scoreboard bench for the ICCM byte-stream loader.
// Expected writes are queued as frames are sent and popped on each strobe.
module tb_iccm_loader;
  import iccm_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        iccm_we_o;
  logic [31:0] iccm_wdata_o;
  logic [31:0] iccm_wmask_o;
  logic [10:0] iccm_waddr_o;
  logic        finish_o;
  logic        err_o;
  logic        busy_o;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total = 0;
  int  strobes = 0;

  always #5 clk = ~clk;

  iccm_loader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_o   (rx_ready_o),
    .iccm_we_o    (iccm_we_o),
    .iccm_wdata_o (iccm_wdata_o),
    .iccm_wmask_o (iccm_wmask_o),
    .iccm_waddr_o (iccm_waddr_o),
    .finish_o     (finish_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (iccm_we_o === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(iccm_waddr_o), 32'(e.a));
        check("wdata", iccm_wdata_o, e.d);
        check("wmask", iccm_wmask_o, 32'hFFFF_FFFF);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic word_bytes(input logic [31:0] d,
                            input bit bad, input int g);
    logic [7:0] cs;
    cs = d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    for (int k = 0; k < 4; k++) begin
      send(d[8*k +: 8]);
      gap(g);
    end
    send(bad ? ~cs : cs);
  endtask

  task automatic write_frame(input logic [10:0] a,
                             input logic [31:0] d,
                             input bit bad,
                             input logic [4:0] junk,
                             input int g);
    wr_t e;
    send(OP_WRITE);
    gap(g);
    send(a[7:0]);
    send({junk, a[10:8]});
    if (!bad) begin
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
    end
    word_bytes(d, bad, g);
  endtask

  task automatic drain(input string tag);
    gap(3);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(iccm_we_o), 32'd0);
    check({tag, "_wdata"}, iccm_wdata_o, 32'd0);
    check({tag, "_wmask"}, iccm_wmask_o, 32'd0);
    check({tag, "_waddr"}, 32'(iccm_waddr_o), 32'd0);
    check({tag, "_finish"}, 32'(finish_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    wr_t e;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    gap(3);
    check_zero("rst");
    check("rst_ready", 32'(rx_ready_o), 32'd0);
    rst_i = 1'b0;
    gap(1);
    check("ready_idle", 32'(rx_ready_o), 32'd1);

    // single write
    write_frame(11'h010, 32'h4433_2211, 1'b0, 5'd0, 0);
    drain("t1_drain");
    check("t1_strobes", 32'(strobes), 32'd1);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd0);

    // burst with address wrap
    send(OP_BURST);
    send(8'hFE);
    send(8'h07);
    send(8'h03);
    send(8'h00);
    check("t2_busy_hdr", 32'(busy_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      e.a = 11'(32'h7FE + i);
      e.d = 32'h1000_0000 * (i + 1) + 32'h0102_0304;
      exp_q.push_back(e);
      word_bytes(e.d, 1'b0, 0);
    end
    drain("t2_drain");
    check("t2_strobes", 32'(strobes), 32'd4);
    check("t2_busy_end", 32'(busy_o), 32'd0);
    check("t2_hold_addr", 32'(iccm_waddr_o), 32'h000);

    // bad checksum then recovery
    write_frame(11'h005, 32'h0403_0201, 1'b1, 5'd0, 0);
    drain("t3_drain_bad");
    check("t3_strobes_bad", 32'(strobes), 32'd4);
    check("t3_err", 32'(err_o), 32'd1);
    write_frame(11'h123, 32'hDEAD_BEEF, 1'b0, 5'd0, 0);
    drain("t3_drain_good");
    check("t3_strobes", 32'(strobes), 32'd5);
    check("t3_err_sticky", 32'(err_o), 32'd1);
    check("t3_hold_data", iccm_wdata_o, 32'hDEAD_BEEF);

    // unknown opcode; upper address-high bits ignored
    send(8'h33);
    gap(1);
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_idle", 32'(busy_o), 32'd0);
    write_frame(11'h2AA, 32'hCAFE_0001, 1'b0, 5'b10101, 0);
    drain("t5_drain");
    check("t5_strobes", 32'(strobes), 32'd6);

    // reset mid-frame
    send(OP_WRITE);
    send(8'h20);
    send(8'h00);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rst_i = 1'b1;
    #1;
    check("t6_ready_rst", 32'(rx_ready_o), 32'd0);
    gap(1);
    check_zero("t6_rst");
    rst_i = 1'b0;
    gap(1);
    check("t6_no_we", 32'(iccm_we_o), 32'd0);
    write_frame(11'h020, 32'h0A0B_0C0D, 1'b0, 5'd0, 2);
    drain("t6_drain");
    check("t6_strobes", 32'(strobes), 32'd7);

    // empty burst, finish, then discard
    send(OP_BURST);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    gap(2);
    check("t4_busy_zero", 32'(busy_o), 32'd0);
    check("t4_finish_pre", 32'(finish_o), 32'd0);
    send(OP_FINISH);
    check("t4_finish", 32'(finish_o), 32'd1);
    check("t4_busy_done", 32'(busy_o), 32'd0);
    send(OP_WRITE);
    send(8'h10);
    send(8'h00);
    word_bytes(32'h4433_2211, 1'b0, 0);
    check("t4_ready", 32'(rx_ready_o), 32'd1);
    gap(3);
    check("t4_strobes", 32'(strobes), 32'd7);
    check("t4_err", 32'(err_o), 32'd0);
    check("t4_finish_sticky", 32'(finish_o), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
- Byte-stream program loader that sits directly upstream of the instruction memory's test/boot write port: tb2iccm_we, tb2mem_wdata, tb2mem_wmask, tb2mem_waddr and tb2mem_finish.
- Parses framed commands from a byte source (SPI/UART deserializer) and issues one 32-bit ICCM word write per validated word.
- Finally asserts a sticky finish that releases core instruction fetch.

Parameters:
AW, 11, ICCM word-address width (2048 words)
DW, 32, ICCM data width; fixed at 4 bytes per word
OP_WRITE, 8'hA5, single-word write opcode
OP_BURST, 8'hB4, multi-word write opcode with auto-increment
OP_FINISH, 8'h5A, end-of-load opcode

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rx_valid_i  in  1  byte valid from upstream deserializer
rx_data_i  in  8  byte payload
rx_ready_o  out  1  byte accept; transfer occurs when rx_valid_i && rx_ready_o
iccm_we_o  out  1  one-cycle ICCM write strobe (to tb2iccm_we)
iccm_wdata_o  out  DW  write data (to tb2mem_wdata)
iccm_wmask_o  out  DW  bit write mask (to tb2mem_wmask)
iccm_waddr_o  out  AW  word address (to tb2mem_waddr)
finish_o  out  1  sticky load-complete flag (to tb2mem_finish)
err_o  out  1  sticky protocol/checksum error
busy_o  out  1  high in any state other than IDLE or DONE

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - All registered outputs are 0: iccm_we_o, iccm_wdata_o, iccm_wmask_o, iccm_waddr_o, finish_o, err_o, busy_o.
  - State = IDLE.
  - rx_ready_o is forced 0 while rst_i is high.
- Reset mid-frame discards all partial state. No write strobe is issued on the reset cycle or the cycle after.
- Multi-byte fields are little-endian.
- Frames:
  - WRITE: A5, addr_lo, addr_hi, d0, d1, d2, d3, csum.
  - BURST: B4, addr_lo, addr_hi, cnt_lo, cnt_hi, then cnt × (d0..d3, csum).
  - FINISH: 5A.
- Address is {addr_hi[2:0], addr_lo}. addr_hi[7:3] is ignored.
- csum = d0^d1^d2^d3, computed per word.
- States: IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA (byte index 0..3), CSUM, WRITE, DONE.
- IDLE, on an accepted byte:
  - A5 → ADDR0 with remaining=1.
  - B4 → ADDR0 with the burst flag set.
  - 5A → DONE.
  - Any other byte: set err_o, drop the byte, stay in IDLE.
- ADDR0 → ADDR1. ADDR1 → CNT0 if burst, else DATA.
- CNT0 → CNT1 → DATA. If the 16-bit count is 0, CNT1 → IDLE and no writes occur.
- DATA:
  - Byte k is placed into word[8k+7:8k]; the XOR accumulator is updated.
  - After the 4th byte → CSUM.
- CSUM:
  - Match → WRITE.
  - Mismatch → set err_o and skip the write. Address increment and remaining decrement still occur so framing is preserved. Next state is DATA if remaining>1, else IDLE.
- WRITE (exactly one cycle):
  - rx_ready_o=0, iccm_we_o=1, iccm_wdata_o=word, iccm_wmask_o=32'hFFFF_FFFF, iccm_waddr_o=addr.
  - Latency: the strobe appears on the cycle immediately after the csum byte is accepted.
  - Next cycle: addr ← addr+1, wrapping 2047→0 modulo 2^AW. remaining ← remaining−1. Next state is DATA if the new remaining ≠ 0, else IDLE.
- rx_ready_o=1 in every state except WRITE.
- DONE:
  - finish_o=1, sticky until reset.
  - rx_ready_o=1; all further bytes are accepted and discarded with no writes and no err_o. This prevents upstream hang.
- iccm_wdata_o, iccm_wmask_o and iccm_waddr_o hold their last values when iccm_we_o=0. The mask returns to 0 only on reset.
- rx_valid_i low stalls parsing in any state. There is no timeout.
- busy_o = state ∉ {IDLE, DONE}.

Decomposition:
- Package iccm_loader_pkg holds:
  - the state enum loader_state_e;
  - opcode localparams OP_WRITE, OP_BURST, OP_FINISH;
  - LOADER_AW and LOADER_DW constants.
- One sub-module, iccm_loader_word_asm, holds the 4-byte little-endian shift/assemble, the byte index counter and the XOR checksum accumulator, with a clear input.
- The top module holds the FSM, the address/count registers and the output registers.

Test Plan:
1. Reset then A5 10 00 11 22 33 44 44 → one iccm_we_o pulse, waddr=0x010, wdata=0x44332211, wmask=0xFFFFFFFF, err_o=0.
2. B4 FE 07 03 00 + 3 valid words → writes at 0x7FE, 0x7FF, 0x000 (wrap); exactly 3 strobes; busy_o falls after the last.
3. A5 05 00 01 02 03 04 00 (bad csum) → no strobe, err_o=1 sticky; a following valid A5 frame still writes correctly.
4. B4 00 00 00 00 then 5A → zero writes, finish_o=1; subsequent bytes (e.g. A5 …) give rx_ready_o=1 and no strobes.
5. Unknown opcode 0x33 → err_o=1, state stays IDLE; the next A5 frame writes normally.
6. Assert rst_i after the 3rd data byte of an A5 frame → no strobe; all outputs 0; rx_ready_o=0 during reset; a fresh frame afterwards writes correctly. rx_valid_i toggling mid-frame produces the same results as back-to-back bytes.
